pe_requant_pack: RTL

Downstream output stage of each PE MAC lane. It captures the 32-bit accumulated result each time the MAC signals completion, then applies bias, rounding right-shift, ReLU/ReLU6 and saturation to 8-bit unsigned. Four quantized activations are packed into one 32-bit word. Packed words are buffered in a small FIFO and delivered to the activation write-back path over a valid/ready handshake.

---
 rtl/pe_requant_pack.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/pe_requant_pack.sv
// pe_requant_pack
// Output stage of a PE MAC lane. Each completed MAC result is requantized
// (bias add, round-half-up right shift, ReLU / ReLU6 clamp, saturation to
// OW-bit unsigned). PACK results are packed into one word, and the words are
// queued in a DEPTH-entry FIFO for the activation write-back path.
//
// Ports
//   clk, rst               clock; asynchronous active-high reset
//   mac_result, mac_done   accumulated result and its one-cycle strobe
//   bias, shift            signed bias and right-shift amount (0..31)
//   relu6_en, six_q        select upper clamp: six_q, or 2^OW-1
//   flush                  one-cycle strobe; emits a partially filled word
//   out_data, out_valid    FIFO head word (lane 0 in the LSBs) and non-empty flag
//   out_ready              consumer accepts the head on out_valid & out_ready
//   overflow               sticky; a completed word was dropped on a full FIFO
module pe_requant_pack #(
    parameter int DW    = 32,
    parameter int OW    = 8,
    parameter int PACK  = 4,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DW-1:0]        mac_result,
    input  logic                 mac_done,
    input  logic [DW-1:0]        bias,
    input  logic [4:0]           shift,
    input  logic                 relu6_en,
    input  logic [OW-1:0]        six_q,
    input  logic                 flush,
    output logic [PACK*OW-1:0]   out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 overflow
);
    localparam int LW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Valid / flush tokens travel with the data; index = stage number.
    logic [3:1] vld_pipe, fl_pipe;

    // S1: widened sum plus the per-element controls.
    logic signed [DW:0]   s1_sum;
    logic [4:0]           s1_shift;
    logic                 s1_r6, s2_r6;
    logic [OW-1:0]        s1_six, s2_six;
    // S2: rounded, shifted value. S3: clamped quantized value.
    logic signed [DW+1:0] s2_r;
    logic [OW-1:0]        s3_q;

    logic signed [DW+1:0] rnd, rsum, r_d;
    logic [DW+1:0]        hi_ext;
    logic [OW-1:0]        hi, q_d;

    // Rounding constant 2^(shift-1); only meaningful for shift != 0.
    always_comb begin
        rnd = '0;
        if (s1_shift != 5'd0)
            rnd = $signed({{(DW+1){1'b0}}, 1'b1} << (s1_shift - 5'd1));
        // One extra bit of headroom so sum + rnd never wraps.
        rsum = $signed({s1_sum[DW], s1_sum}) + rnd;
        r_d  = rsum >>> s1_shift;
    end

    always_comb begin
        hi     = s2_r6 ? s2_six : {OW{1'b1}};
        hi_ext = {{(DW+2-OW){1'b0}}, hi};
        if (s2_r[DW+1])
            q_d = '0;
        else if ($unsigned(s2_r) > hi_ext)
            q_d = hi;
        else
            q_d = s2_r[OW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            fl_pipe  <= '0;
            s1_sum   <= '0;
            s1_shift <= '0;
            s1_r6    <= 1'b0;
            s1_six   <= '0;
            s2_r     <= '0;
            s2_r6    <= 1'b0;
            s2_six   <= '0;
            s3_q     <= '0;
        end else begin
            vld_pipe <= {vld_pipe[2:1], mac_done};
            fl_pipe  <= {fl_pipe[2:1], flush};
            s1_sum   <= $signed({mac_result[DW-1], mac_result}) + $signed({bias[DW-1], bias});
            s1_shift <= shift;
            s1_r6    <= relu6_en;
            s1_six   <= six_q;
            s2_r     <= r_d;
            s2_r6    <= s1_r6;
            s2_six   <= s1_six;
            s3_q     <= q_d;
        end
    end

    // Packer. The staged lanes are cleared on every push, so lanes not yet
    // written in a partial word already read as zero.
    logic [LW-1:0]                lane, lane_n;
    logic [PACK-2:0][OW-1:0]      staged, staged_n;
    logic [OW-1:0]                top_lane;
    logic                         push;
    logic [PACK*OW-1:0]           push_word;

    always_comb begin
        staged_n = staged;
        top_lane = '0;
        push     = 1'b0;
        lane_n   = lane;
        if (vld_pipe[3]) begin
            if (lane == LW'(PACK-1)) begin
                top_lane = s3_q;
                push     = 1'b1;
                lane_n   = '0;
            end else begin
                for (int i = 0; i < PACK-1; i++)
                    if (lane == LW'(i)) staged_n[i] = s3_q;
                lane_n = lane + LW'(1);
            end
        end
        // Flush acts after the insert; a word that just completed leaves
        // lane_n at 0, which makes the flush a no-op.
        if (fl_pipe[3] && lane_n != '0) begin
            push   = 1'b1;
            lane_n = '0;
        end
        push_word = {top_lane, staged_n};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane   <= '0;
            staged <= '0;
        end else begin
            lane   <= lane_n;
            staged <= push ? '0 : staged_n;
        end
    end

    // Output FIFO.
    logic [DEPTH-1:0][PACK*OW-1:0] mem;
    logic [AW-1:0]                 wr_ptr, rd_ptr;
    logic [AW:0]                   count;
    logic                          full, pop, wr_en;

    assign full      = (count == (AW+1)'(DEPTH));
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a push on full is accepted.
    assign wr_en     = push & (~full | pop);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

endmodule
